// File: rtl/fetch_sequencer.sv
// Fetch-PC sequencer: owns the fetch PC, issues one fetch at a time, and hands
// returned instructions (with their prediction tags) to ID through a one-entry buffer.
module fetch_sequencer #(
  parameter int unsigned W        = 32,
  parameter logic [W-1:0] RESET_PC = W'(32'h8000_0000)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  output logic [W-1:0] pd_pc_o,
  input  logic         pd_taken_i,
  input  logic [W-1:0] pd_targetPc_i,
  input  logic         pd_failed_i,
  input  logic [W-1:0] pd_flushPc_i,
  input  logic         ex_redirect_i,
  input  logic [W-1:0] ex_redirect_pc_i,
  output logic         if_req_o,
  output logic [W-1:0] if_pc_o,
  input  logic         if_ready_i,
  input  logic         if_resp_valid_i,
  input  logic [W-1:0] if_resp_inst_i,
  output logic         id_valid_o,
  input  logic         id_ready_i,
  output logic [W-1:0] id_pc_o,
  output logic [W-1:0] id_inst_o,
  output logic         id_predTaken_o,
  output logic [W-1:0] id_predTarget_o,
  output logic         id_flush_o
);

  typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} state_t;

  state_t       state;
  logic [W-1:0] pc_q;
  logic [W-1:0] req_pc_q;
  logic         req_taken_q;
  logic [W-1:0] req_target_q;
  logic         drop_q;
  logic [W-1:0] buf_inst_q;

  logic         redirect;
  logic [W-1:0] redirect_pc;
  logic [W-1:0] next_seq_pc;
  logic         resp_live;

  // Exception redirect outranks a predictor flush.
  assign redirect    = ex_redirect_i | pd_failed_i;
  assign redirect_pc = ex_redirect_i ? ex_redirect_pc_i : pd_flushPc_i;
  assign next_seq_pc = pd_taken_i ? pd_targetPc_i : pc_q + W'(4);
  assign resp_live   = (state == WAIT) && if_resp_valid_i && !drop_q && !redirect;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= BOOT;
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      req_taken_q  <= 1'b0;
      req_target_q <= '0;
      drop_q       <= 1'b0;
      buf_inst_q   <= '0;
    end else begin
      case (state)
        BOOT: state <= REQ;
        REQ: begin
          if (if_ready_i) begin
            req_pc_q     <= pc_q;
            req_taken_q  <= pd_taken_i;
            req_target_q <= pd_targetPc_i;
            pc_q         <= next_seq_pc;
            drop_q       <= redirect;
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (if_resp_valid_i) begin
            drop_q <= 1'b0;
            if (drop_q || redirect || id_ready_i) begin
              state <= REQ;
            end else begin
              buf_inst_q <= if_resp_inst_i;
              state      <= HOLD;
            end
          end else if (redirect) begin
            drop_q <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect || id_ready_i) state <= REQ;
        end
        default: state <= BOOT;
      endcase
      // A redirect target beats every other PC update, including the acceptance step.
      if (redirect) pc_q <= redirect_pc;
    end
  end

  assign if_req_o        = (state == REQ);
  assign if_pc_o         = pc_q;
  assign pd_pc_o         = pc_q;
  assign id_flush_o      = redirect && (state != BOOT);
  assign id_valid_o      = resp_live || ((state == HOLD) && !redirect);
  assign id_inst_o       = (state == WAIT) ? if_resp_inst_i : buf_inst_q;
  assign id_pc_o         = req_pc_q;
  assign id_predTaken_o  = req_taken_q;
  assign id_predTarget_o = req_target_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer: a transaction-level model predicts fetch
// addresses and ID handoffs; a monitor checks every presented ID instruction.
module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] pd_pc_o;
  logic        pd_taken_i;
  logic [31:0] pd_targetPc_i;
  logic        pd_failed_i;
  logic [31:0] pd_flushPc_i;
  logic        ex_redirect_i;
  logic [31:0] ex_redirect_pc_i;
  logic        if_req_o;
  logic [31:0] if_pc_o;
  logic        if_ready_i;
  logic        if_resp_valid_i;
  logic [31:0] if_resp_inst_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_predTaken_o;
  logic [31:0] id_predTarget_o;
  logic        id_flush_o;

  always #5 clk = ~clk;

  fetch_sequencer #(.W(32), .RESET_PC(RESET_PC)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .pd_pc_o(pd_pc_o), .pd_taken_i(pd_taken_i), .pd_targetPc_i(pd_targetPc_i),
    .pd_failed_i(pd_failed_i), .pd_flushPc_i(pd_flushPc_i),
    .ex_redirect_i(ex_redirect_i), .ex_redirect_pc_i(ex_redirect_pc_i),
    .if_req_o(if_req_o), .if_pc_o(if_pc_o), .if_ready_i(if_ready_i),
    .if_resp_valid_i(if_resp_valid_i), .if_resp_inst_i(if_resp_inst_i),
    .id_valid_o(id_valid_o), .id_ready_i(id_ready_i), .id_pc_o(id_pc_o),
    .id_inst_o(id_inst_o), .id_predTaken_o(id_predTaken_o),
    .id_predTarget_o(id_predTarget_o), .id_flush_o(id_flush_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        taken;
    logic [31:0] target;
  } item_t;

  typedef enum {M_BOOT, M_IDLE, M_OUT, M_HELD} mphase_t;

  item_t       exp_q[$];
  int          errors = 0;
  int          checks = 0;

  mphase_t     m_phase = M_BOOT;
  logic [31:0] m_pc    = RESET_PC;
  item_t       m_item;
  logic        m_doomed;

  int p_rst, p_ready, p_resp, p_spur, p_idr, p_red, p_both, p_taken;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit roll(input int pct);
    return $urandom_range(99) < pct;
  endfunction

  // Reference model: one fetch in flight, one instruction held; evaluated mid-cycle.
  initial begin
    forever begin
      logic        red;
      logic [31:0] rpc;
      @(negedge clk);
      red = ex_redirect_i | pd_failed_i;
      rpc = ex_redirect_i ? ex_redirect_pc_i : pd_flushPc_i;
      if (rst_i) begin
        m_phase = M_BOOT;
        m_pc    = RESET_PC;
      end else begin
        case (m_phase)
          M_BOOT: begin
            chk("boot_if_req", 32'(if_req_o), 32'd0);
            chk("boot_flush", 32'(id_flush_o), 32'd0);
            chk("boot_id_valid", 32'(id_valid_o), 32'd0);
            chk("boot_if_pc", if_pc_o, RESET_PC);
            chk("boot_pd_pc", pd_pc_o, RESET_PC);
            chk("boot_id_pc", id_pc_o, 32'd0);
            chk("boot_id_inst", id_inst_o, 32'd0);
            chk("boot_id_taken", 32'(id_predTaken_o), 32'd0);
            chk("boot_id_target", id_predTarget_o, 32'd0);
            m_phase = M_IDLE;
          end
          M_IDLE: begin
            chk("flush", 32'(id_flush_o), 32'(red));
            chk("if_req", 32'(if_req_o), 32'd1);
            chk("if_pc", if_pc_o, m_pc);
            chk("pd_pc", pd_pc_o, m_pc);
            if (if_ready_i) begin
              m_item.pc     = m_pc;
              m_item.taken  = pd_taken_i;
              m_item.target = pd_targetPc_i;
              m_doomed      = red;
              m_phase       = M_OUT;
              m_pc          = pd_taken_i ? pd_targetPc_i : m_pc + 32'd4;
            end
          end
          M_OUT: begin
            chk("flush", 32'(id_flush_o), 32'(red));
            chk("if_req_busy", 32'(if_req_o), 32'd0);
            if (if_resp_valid_i) begin
              if (m_doomed || red) begin
                m_phase = M_IDLE;
              end else begin
                m_item.inst = if_resp_inst_i;
                exp_q.push_back(m_item);
                m_phase = id_ready_i ? M_IDLE : M_HELD;
              end
            end else if (red) begin
              m_doomed = 1'b1;
            end
          end
          M_HELD: begin
            chk("flush", 32'(id_flush_o), 32'(red));
            chk("if_req_busy", 32'(if_req_o), 32'd0);
            if (red) begin
              m_phase = M_IDLE;
            end else begin
              exp_q.push_back(m_item);
              if (id_ready_i) m_phase = M_IDLE;
            end
          end
          default: m_phase = M_BOOT;
        endcase
        if (red) m_pc = rpc;
      end
    end
  end

  // Monitor: every cycle ID sees a valid instruction must match the model's next entry.
  initial begin
    forever begin
      item_t e;
      @(negedge clk);
      #1;
      if (!rst_i && id_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("id_unexpected_valid", 32'(id_valid_o), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("id_pc", id_pc_o, e.pc);
          chk("id_inst", id_inst_o, e.inst);
          chk("id_taken", 32'(id_predTaken_o), 32'(e.taken));
          chk("id_target", id_predTarget_o, e.target);
        end
      end
    end
  end

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      rst_i            = roll(p_rst);
      if_ready_i       = roll(p_ready);
      if_resp_valid_i  = (m_phase == M_OUT) ? roll(p_resp) : roll(p_spur);
      if_resp_inst_i   = $urandom();
      id_ready_i       = roll(p_idr);
      pd_taken_i       = roll(p_taken);
      pd_targetPc_i    = $urandom() & 32'hFFFF_FFFC;
      pd_flushPc_i     = $urandom() & 32'hFFFF_FFFC;
      ex_redirect_pc_i = $urandom() & 32'hFFFF_FFFC;
      if (roll(p_red)) begin
        if (roll(p_both)) begin
          pd_failed_i   = 1'b1;
          ex_redirect_i = 1'b1;
        end else begin
          pd_failed_i   = roll(50);
          ex_redirect_i = !pd_failed_i;
        end
      end else begin
        pd_failed_i   = 1'b0;
        ex_redirect_i = 1'b0;
      end
    end
  endtask

  task automatic knobs(input int rs, input int rdy, input int rsp, input int sp,
                       input int idr, input int red, input int both, input int tk);
    p_rst = rs; p_ready = rdy; p_resp = rsp; p_spur = sp;
    p_idr = idr; p_red = red; p_both = both; p_taken = tk;
  endtask

  initial begin
    rst_i = 1'b1; if_ready_i = 1'b0; if_resp_valid_i = 1'b0; if_resp_inst_i = '0;
    id_ready_i = 1'b0; pd_taken_i = 1'b0; pd_targetPc_i = '0; pd_failed_i = 1'b0;
    pd_flushPc_i = '0; ex_redirect_i = 1'b0; ex_redirect_pc_i = '0;

    knobs(100, 0, 0, 0, 0, 0, 0, 0);     run(3);
    knobs(0, 100, 100, 0, 100, 0, 0, 0); run(20);    // straight-line fetch, best-case rate
    knobs(0, 100, 100, 0, 100, 0, 0, 50); run(30);   // predicted-taken targets
    knobs(0, 70, 60, 20, 20, 0, 0, 30);  run(60);    // ID back-pressure into the holding buffer
    knobs(0, 80, 60, 20, 70, 25, 50, 30); run(100);  // redirects, including simultaneous ones
    knobs(8, 80, 50, 60, 60, 10, 30, 30); run(200);  // resets mid-transaction with stale responses
    knobs(2, 60, 50, 15, 60, 12, 20, 40); run(3000); // mixed random traffic
    knobs(0, 100, 100, 0, 100, 0, 0, 0); run(10);

    @(negedge clk);
    #2;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Fetch-PC sequencer between the branch predictor and the instruction fetch port. Owns the architectural fetch PC and drives the fetch request handshake. Picks each next PC from exception redirect, predictor flush, predicted target or PC+4. Hands fetched instructions, with their prediction tags, to ID through a one-entry holding buffer, and drops wrong-path responses after a redirect.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, first fetch address after reset
- W, `RegW (32), PC/instruction width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- pd_pc_o  out  W  predictor lookup PC; always equals if_pc_o
- pd_taken_i  in  1  predictor says taken for pd_pc_o
- pd_targetPc_i  in  W  predicted target for pd_pc_o
- pd_failed_i  in  1  ID-stage misprediction detected
- pd_flushPc_i  in  W  correct PC on misprediction
- ex_redirect_i  in  1  exception/ertn redirect
- ex_redirect_pc_i  in  W  redirect target
- if_req_o  out  1  fetch request valid
- if_pc_o  out  W  fetch address
- if_ready_i  in  1  fetch port accepts request
- if_resp_valid_i  in  1  instruction returned for the oldest accepted request
- if_resp_inst_i  in  W  returned instruction
- id_valid_o  out  1  instruction valid to ID
- id_ready_i  in  1  ID accepts instruction
- id_pc_o, id_inst_o  out  W  PC/instruction to ID
- id_predTaken_o  out  1  prediction used for this instruction
- id_predTarget_o  out  W  predicted target used
- id_flush_o  out  1  kill IF/ID register this cycle

## Operation
- Registers: pc_q, state, req_pc_q, req_taken_q, req_target_q, drop_q, buf_inst_q.
- redirect = ex_redirect_i | pd_failed_i; redirect_pc = ex_redirect_i ? ex_redirect_pc_i : pd_flushPc_i. Exception has priority.
- id_flush_o = redirect in every state except BOOT.
- Any redirect loads pc_q <= redirect_pc. This overrides all other pc_q updates.
- States:
  - **BOOT**: entered on reset. if_req_o=0. Goes to REQ next cycle.
  - **REQ**: if_req_o=1, if_pc_o=pc_q.
    - Before acceptance, the address may change only on a redirect.
    - On if_ready_i, the request is accepted. Capture req_pc_q=pc_q, req_taken_q=pd_taken_i, req_target_q=pd_targetPc_i. Set pc_q <= pd_taken_i ? pd_targetPc_i : pc_q+4 (mod 2^W). Go to WAIT.
    - If a redirect occurs in the acceptance cycle: set drop_q=1 and go to WAIT. The redirect target wins pc_q.
  - **WAIT**: if_req_o=0.
    - A redirect sets drop_q=1.
    - On if_resp_valid_i with drop_q=1 or a redirect this cycle: discard the response, clear drop_q, go to REQ.
    - Otherwise: id_valid_o=1, with id_* taken from if_resp_inst_i and the req_* registers.
      - If id_ready_i=1, go to REQ.
      - Else latch the instruction into buf_inst_q and go to HOLD.
  - **HOLD**: id_valid_o=1, with id_* from buf_inst_q and the req_* registers.
    - If id_ready_i=1, go to REQ.
    - A redirect discards the buffer (id_valid_o=0 that cycle) and goes to REQ.
- if_resp_valid_i is ignored in BOOT, REQ and HOLD. This covers stale responses after a reset mid-transaction.
- At most one fetch request is outstanding.

## Timing
- Reset values:
  - if_req_o=0, id_valid_o=0, id_flush_o=0, id_predTaken_o=0
  - if_pc_o=pd_pc_o=RESET_PC
  - id_pc_o/id_inst_o/id_predTarget_o=0
  - drop_q=0, state=BOOT
- First request: if_req_o=1 in the first cycle after rst_i deasserts.
- Best-case throughput: one instruction per 2 cycles. Accept in cycle N, response and ID handoff in N+1, next request in N+2.
- Redirect latency:
  - The redirected address appears on if_pc_o the cycle after the redirect, in REQ, or at the next REQ entry.
  - id_flush_o is combinational in the redirect cycle.
- Simultaneous redirect and response in WAIT: the response is dropped and drop_q stays 0.
- Simultaneous ex_redirect_i and pd_failed_i: ex_redirect_pc_i is used.
- No instruction is ever issued to ID with drop_q=1.
- No duplicate issue: each accepted request produces at most one id_valid_o&id_ready_i transfer.

## Test plan
- Reset then fetch with if_ready_i=1, one-cycle responses, pd_taken_i=0 → if_pc_o sequence 8000_0000, 8000_0004, 8000_0008; id_valid_o every other cycle.
- pd_taken_i=1, pd_targetPc_i=8000_0040 at PC 8000_0008 → next request at 8000_0040; id_predTaken_o=1, id_predTarget_o=8000_0040 on that instruction.
- Accept 8000_0010, pd_failed_i=1 with pd_flushPc_i=8000_0100 during WAIT → id_flush_o=1; response for 8000_0010 dropped; next request 8000_0100.
- Response arrives with id_ready_i=0 for 3 cycles → HOLD; id_inst_o stable; transfer on the 4th cycle; next request follows.
- ex_redirect_i (8000_0200) and pd_failed_i (8000_0300) in the same cycle → next request 8000_0200.
- rst_i asserted during WAIT, then a response arrives → response ignored; if_pc_o=8000_0000; id_valid_o stays 0.
